// File: rtl/debounce_sched_pkg.sv
// Shared types and helpers for the debounce event scheduler.
//   state_t      : arbiter FSM states
//   rr_grant_t   : round-robin pick result (found flag + channel index)
//   rr_pick()    : first pending channel at or above ptr, wrapping at channels
//   TSW_DEFAULT  : default timestamp width when EVT_TIMESTAMP_EN is defined
package debounce_sched_pkg;

    localparam int unsigned MAX_CH      = 16;
    localparam int unsigned PTR_W       = 4;
    localparam int unsigned TSW_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_grant_t;

    // Search ptr, ptr+1, ... with wrap at channels-1; indices >= channels are never picked.
    function automatic rr_grant_t rr_pick(
        input logic [MAX_CH-1:0] pending,
        input logic [PTR_W-1:0]  ptr,
        input int unsigned       channels
    );
        rr_grant_t   g;
        int unsigned idx;
        g = '0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= channels) begin
                idx = idx - channels;
            end
            if (!g.found && (k < channels) && (idx < channels) && pending[idx[PTR_W-1:0]]) begin
                g.found = 1'b1;
                g.idx   = idx[PTR_W-1:0];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/debounce_event_scheduler_ce_prescaler.sv
// Clock-enable prescaler: emits a registered one-cycle ce_out every PRESCALE
// cycles while enable is high. Dropping enable zeroes the count, so the first
// tick after re-enable comes PRESCALE cycles later.
//   clk, rst_n : clock, async active-low reset
//   enable     : run the prescaler
//   ce_out     : one-cycle tick
module ce_prescaler #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic ce_out
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;

    // Terminal count produces the tick one cycle later, keeping the period exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            ce_out <= 1'b0;
        end else if (!enable) begin
            cnt_q  <= '0;
            ce_out <= 1'b0;
        end else if (cnt_q == CW'(PRESCALE - 1)) begin
            cnt_q  <= '0;
            ce_out <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
            ce_out <= 1'b0;
        end
    end

endmodule

// File: rtl/debounce_event_scheduler.sv
// Debounce event scheduler: generates the shared filter clock-enable tick,
// captures per-channel "new stable level" pulses into pending flags and
// round-robin arbitrates them onto a valid/ready event stream.
// Optional build macro EVT_TIMESTAMP_EN adds parameter TSW and output evt_ts
// (ce tick count sampled at grant).
//   enable      : run the prescaler        ce_out    : filter clock-enable tick
//   flt_event   : per-channel event pulse  flt_level : per-channel filtered level
//   evt_valid/evt_ready/evt_id/evt_level   : event stream
//   overrun     : sticky lost-event flag   overrun_clr : clear overrun
module debounce_event_scheduler
    import debounce_sched_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned IDW      = $clog2(CHANNELS)
`ifdef EVT_TIMESTAMP_EN
    ,
    parameter int unsigned TSW      = TSW_DEFAULT
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic                ce_out,
    input  logic [CHANNELS-1:0] flt_event,
    input  logic [CHANNELS-1:0] flt_level,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDW-1:0]      evt_id,
    output logic                evt_level,
`ifdef EVT_TIMESTAMP_EN
    output logic [TSW-1:0]      evt_ts,
`endif
    output logic                overrun,
    input  logic                overrun_clr
);

    state_t                state_q, state_d;
    logic [CHANNELS-1:0]   pending_q, pending_d;
    logic [CHANNELS-1:0]   clr_mask;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        evt_id_d;
    logic                  evt_valid_d;
    logic                  evt_level_d;
    logic                  overrun_d;
    logic                  overrun_set;
    rr_grant_t             grant;
    logic [IDW-1:0]        gidx;

    // Shared tick generator
    ce_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .ce_out (ce_out)
    );

    assign grant = rr_pick(MAX_CH'(pending_q), PTR_W'(ptr_q), CHANNELS);
    assign gidx  = IDW'(grant.idx);

`ifdef EVT_TIMESTAMP_EN
    logic [TSW-1:0] ts_q;
    logic [TSW-1:0] evt_ts_d;

    // Free-running tick counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (ce_out) begin
            ts_q <= ts_q + TSW'(1);
        end
    end
`endif

    // Arbiter next-state, grant and capture logic
    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid;
        evt_id_d    = evt_id;
        evt_level_d = evt_level;
        ptr_d       = ptr_q;
        clr_mask    = '0;
`ifdef EVT_TIMESTAMP_EN
        evt_ts_d    = evt_ts;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant.found) begin
                    evt_id_d    = gidx;
                    evt_level_d = flt_level[gidx];
                    evt_valid_d = 1'b1;
                    clr_mask    = CHANNELS'(1) << gidx;
`ifdef EVT_TIMESTAMP_EN
                    evt_ts_d    = ts_q;
`endif
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    ptr_d       = (evt_id == IDW'(CHANNELS - 1)) ? '0 : evt_id + IDW'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new event wins over a same-cycle grant clear; a set on a still-pending bit is lost.
        pending_d   = (pending_q & ~clr_mask) | flt_event;
        overrun_set = |(flt_event & pending_q & ~clr_mask);
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_level <= 1'b0;
            overrun   <= 1'b0;
`ifdef EVT_TIMESTAMP_EN
            evt_ts    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            evt_valid <= evt_valid_d;
            evt_id    <= evt_id_d;
            evt_level <= evt_level_d;
            overrun   <= overrun_d;
`ifdef EVT_TIMESTAMP_EN
            evt_ts    <= evt_ts_d;
`endif
        end
    end

endmodule

// File: tb/tb_debounce_event_scheduler.sv
// Directed self-checking bench for debounce_event_scheduler (CHANNELS=4, PRESCALE=4).
module tb_debounce_event_scheduler;

    localparam int unsigned CH = 4;
    localparam int unsigned PS = 4;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          ce_out;
    logic [CH-1:0] flt_event;
    logic [CH-1:0] flt_level;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_id;
    logic          evt_level;
    logic          overrun;
    logic          overrun_clr;
`ifdef EVT_TIMESTAMP_EN
    logic [15:0]   evt_ts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    debounce_event_scheduler #(
        .CHANNELS (CH),
        .PRESCALE (PS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .ce_out      (ce_out),
        .flt_event   (flt_event),
        .flt_level   (flt_level),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .evt_level   (evt_level),
`ifdef EVT_TIMESTAMP_EN
        .evt_ts      (evt_ts),
`endif
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse pattern for one cycle, then expect n events (ids packed 4 bits each), 2 cycles apart
    task automatic burst(input string tag, input logic [3:0] pat, input logic [3:0] lvl,
                         input int n, input logic [15:0] ids);
        logic [3:0] id;
        flt_level = lvl;
        flt_event = pat;
        step();
        flt_event = '0;
        check({tag, "_latency"}, 32'(evt_valid), 32'd0);
        for (int k = 0; k < n; k++) begin
            id = ids[4*k +: 4];
            step();
            check($sformatf("%s_valid%0d", tag, k), 32'(evt_valid), 32'd1);
            check($sformatf("%s_id%0d", tag, k), 32'(evt_id), 32'(id));
            check($sformatf("%s_lvl%0d", tag, k), 32'(evt_level), 32'(lvl[id]));
            step();
            check($sformatf("%s_gap%0d", tag, k), 32'(evt_valid), 32'd0);
        end
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        flt_event   = '0;
        flt_level   = '0;
        evt_ready   = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ce", 32'(ce_out), 32'd0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_id", 32'(evt_id), 32'd0);
        check("rst_level", 32'(evt_level), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Prescaler: ticks after edges 4 and 8, disable at 10, re-enable after 13 -> tick at 17
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("ce_c%0d", k), 32'(ce_out), 32'((k % 4) == 0));
        end
        enable = 1'b0;
        for (int k = 11; k <= 13; k++) begin
            step();
            check($sformatf("ce_off_c%0d", k), 32'(ce_out), 32'd0);
        end
        enable = 1'b1;
        for (int k = 14; k <= 17; k++) begin
            step();
            check($sformatf("ce_re_c%0d", k), 32'(ce_out), 32'(k == 17));
        end
        enable = 1'b0;
        step();

        // Round-robin with ready held high
        evt_ready = 1'b1;
        burst("rr1", 4'b1011, 4'b0010, 3, {4'd0, 4'd3, 4'd1, 4'd0});
        burst("rr2", 4'b0011, 4'b0001, 2, {4'd0, 4'd0, 4'd1, 4'd0});
        burst("single", 4'b0100, 4'b0100, 1, {4'd0, 4'd0, 4'd0, 4'd2});
        // ptr is now 3: ch3 first, then wrap to ch0
        burst("wrap", 4'b1001, 4'b1000, 2, {4'd0, 4'd0, 4'd0, 4'd3});

        // Backpressure on ch1 (ptr is 1)
        evt_ready = 1'b0;
        flt_level = 4'b0010;
        flt_event = 4'b0010;
        step();
        flt_event = '0;
        step();
        check("bp_valid", 32'(evt_valid), 32'd1);
        check("bp_id", 32'(evt_id), 32'd1);
        flt_level = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            flt_event = (k == 3 || k == 6) ? 4'b0010 : 4'b0000;
            step();
            flt_event = '0;
            check($sformatf("bp_hold_valid%0d", k), 32'(evt_valid), 32'd1);
            check($sformatf("bp_hold_id%0d", k), 32'(evt_id), 32'd1);
            check($sformatf("bp_hold_lvl%0d", k), 32'(evt_level), 32'd1);
            check($sformatf("bp_ovr%0d", k), 32'(overrun), 32'(k >= 6));
        end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        evt_ready = 1'b1;
        step();
        check("bp_release", 32'(evt_valid), 32'd0);
        step();
        check("bp_second_valid", 32'(evt_valid), 32'd1);
        check("bp_second_id", 32'(evt_id), 32'd1);
        check("bp_second_lvl", 32'(evt_level), 32'd0);
        step();
        check("bp_second_done", 32'(evt_valid), 32'd0);

        // Collision: ch0 re-fires in the cycle it is granted
        flt_level = 4'b0001;
        flt_event = 4'b0001;
        step();
        check("col_pend", 32'(evt_valid), 32'd0);
        step();
        flt_event = '0;
        check("col_g1_valid", 32'(evt_valid), 32'd1);
        check("col_g1_id", 32'(evt_id), 32'd0);
        step();
        check("col_g1_done", 32'(evt_valid), 32'd0);
        step();
        check("col_g2_valid", 32'(evt_valid), 32'd1);
        check("col_g2_id", 32'(evt_id), 32'd0);
        check("col_ovr", 32'(overrun), 32'd0);
        step();
        check("col_g2_done", 32'(evt_valid), 32'd0);

        // Reset mid-offer: ch2 offered (ptr=1), ch0 still pending
        evt_ready = 1'b0;
        flt_level = 4'b0100;
        flt_event = 4'b0101;
        step();
        flt_event = '0;
        step();
        check("mid_valid", 32'(evt_valid), 32'd1);
        check("mid_id", 32'(evt_id), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_id", 32'(evt_id), 32'd0);
        check("mid_rst_lvl", 32'(evt_level), 32'd0);
        #1;
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        enable    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k <= 3) begin
                check($sformatf("mid_pend_clr%0d", k), 32'(evt_valid), 32'd0);
            end
        end
        check("ts_ce20", 32'(ce_out), 32'd1);
        flt_level = 4'b0001;
        flt_event = 4'b0001;
        step();
        flt_event = '0;
        step();
        check("ts_valid", 32'(evt_valid), 32'd1);
        check("ts_id", 32'(evt_id), 32'd0);
`ifdef EVT_TIMESTAMP_EN
        check("ts_value", 32'(evt_ts), 32'd5);
`endif
        step();
        check("ts_done", 32'(evt_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
